// File: rtl/mem_line_initiator_pkg.sv
// Shared constants and state encoding for the beat-serialized memory protocol initiator.
// Defaults match the block-RAM memory responder on the other side of the port.
package mem_line_initiator_pkg;

    localparam int MEM_ADDR_BITS_DEF   = 26;
    localparam int MEM_DATA_BITS_DEF   = 128;
    localparam int MEM_TAG_BITS_DEF    = 4;
    localparam int MEM_DATA_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } mli_state_e;

    // Beat counter width; a line always has at least two beats.
    function automatic int beat_cnt_bits(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_line_initiator_deserializer.sv
// Collects read response beats into a line and pulses line_val the cycle after the last beat.
// The visible line only changes on completion, so it stays stable while the next read is collected.
module mem_line_deserializer
    import mem_line_initiator_pkg::*;
#(
    parameter int MEM_DATA_BITS   = MEM_DATA_BITS_DEF,
    parameter int MEM_TAG_BITS    = MEM_TAG_BITS_DEF,
    parameter int MEM_DATA_CYCLES = MEM_DATA_CYCLES_DEF,
    localparam int LINE_BITS      = MEM_DATA_BITS * MEM_DATA_CYCLES,
    localparam int CNT_BITS       = beat_cnt_bits(MEM_DATA_CYCLES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat_val,
    input  logic [MEM_DATA_BITS-1:0] beat_data,
    input  logic [MEM_TAG_BITS-1:0]  txn_tag,
    output logic                     last_beat,
    output logic                     line_val,
    output logic [LINE_BITS-1:0]     line_data,
    output logic [MEM_TAG_BITS-1:0]  line_tag
);

    localparam logic [CNT_BITS-1:0] LAST_SLOT = CNT_BITS'(MEM_DATA_CYCLES - 1);

    logic [CNT_BITS-1:0]      rcnt_q, rcnt_d;
    logic                     line_val_q, line_val_d;
    logic [LINE_BITS-1:0]     line_data_q;
    logic [MEM_TAG_BITS-1:0]  line_tag_q;
    logic [MEM_DATA_BITS-1:0] beats_q [MEM_DATA_CYCLES-1];
    logic [LINE_BITS-1:0]     assembled;

    always_comb begin
        rcnt_d     = rcnt_q;
        last_beat  = beat_val && (rcnt_q == LAST_SLOT);
        line_val_d = last_beat;
        if (beat_val) begin
            rcnt_d = rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q     <= '0;
            line_val_q <= 1'b0;
        end else begin
            rcnt_q     <= rcnt_d;
            line_val_q <= line_val_d;
        end
    end

    // Early beats park in a staging buffer; the final beat goes straight into the top slot.
    for (genvar gi = 0; gi < MEM_DATA_CYCLES - 1; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (beat_val && (rcnt_q == CNT_BITS'(gi))) begin
                beats_q[gi] <= beat_data;
            end
        end
        assign assembled[gi*MEM_DATA_BITS +: MEM_DATA_BITS] = beats_q[gi];
    end
    assign assembled[(MEM_DATA_CYCLES-1)*MEM_DATA_BITS +: MEM_DATA_BITS] = beat_data;

    always_ff @(posedge clk) begin
        if (last_beat) begin
            line_data_q <= assembled;
            line_tag_q  <= txn_tag;
        end
    end

    assign line_val  = line_val_q;
    assign line_data = line_data_q;
    assign line_tag  = line_tag_q;

endmodule

// File: rtl/mem_line_initiator.sv
// Line-level client of the beat-serialized memory port: serializes write lines into beats,
// issues reads as a single request beat and returns the reassembled response line.
module mem_line_initiator
    import mem_line_initiator_pkg::*;
#(
    parameter int MEM_ADDR_BITS   = MEM_ADDR_BITS_DEF,
    parameter int MEM_DATA_BITS   = MEM_DATA_BITS_DEF,
    parameter int MEM_TAG_BITS    = MEM_TAG_BITS_DEF,
    parameter int MEM_DATA_CYCLES = MEM_DATA_CYCLES_DEF,
    localparam int LINE_BITS      = MEM_DATA_BITS * MEM_DATA_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     line_req_val,
    output logic                     line_req_rdy,
    input  logic                     line_req_rw,
    input  logic [MEM_ADDR_BITS-1:0] line_req_addr,
    input  logic [LINE_BITS-1:0]     line_req_data,
    input  logic [MEM_TAG_BITS-1:0]  line_req_tag,

    output logic                     line_resp_val,
    output logic [LINE_BITS-1:0]     line_resp_data,
    output logic [MEM_TAG_BITS-1:0]  line_resp_tag,

    output logic                     mem_req_val,
    input  logic                     mem_req_rdy,
    output logic                     mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic [MEM_DATA_BITS-1:0] mem_req_data,
    output logic [MEM_TAG_BITS-1:0]  mem_req_tag,

    input  logic                     mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
    input  logic [MEM_TAG_BITS-1:0]  mem_resp_tag,

    output logic                     proto_error
);

    localparam int CNT_BITS = beat_cnt_bits(MEM_DATA_CYCLES);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(MEM_DATA_CYCLES - 1);

    mli_state_e               state_q, state_d;
    logic [CNT_BITS-1:0]      wcnt_q, wcnt_d;
    logic                     proto_error_q, proto_error_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [MEM_TAG_BITS-1:0]  tag_q, tag_d;
    logic [LINE_BITS-1:0]     data_q, data_d;

    logic                     rd_beat_val;
    logic                     rd_last_beat;
    logic [MEM_DATA_BITS-1:0] wbeats [MEM_DATA_CYCLES];

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        addr_d        = addr_q;
        tag_d         = tag_q;
        data_d        = data_q;
        proto_error_d = proto_error_q;

        case (state_q)
            IDLE: begin
                if (line_req_val) begin
                    addr_d  = line_req_addr;
                    tag_d   = line_req_tag;
                    data_d  = line_req_data;
                    state_d = line_req_rw ? WRITE : RD_REQ;
                end
            end
            WRITE: begin
                if (mem_req_rdy) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_REQ: begin
                if (mem_req_rdy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Mismatched tags are flagged but the beat is still stored and counted.
        if (mem_resp_val && ((state_q != RD_WAIT) || (mem_resp_tag != tag_q))) begin
            proto_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            proto_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            proto_error_q <= proto_error_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    for (genvar gi = 0; gi < MEM_DATA_CYCLES; gi++) begin : g_wbeat
        assign wbeats[gi] = data_q[gi*MEM_DATA_BITS +: MEM_DATA_BITS];
    end

    assign line_req_rdy = (state_q == IDLE) && !reset;
    assign mem_req_val  = (state_q == WRITE) || (state_q == RD_REQ);
    assign mem_req_rw   = (state_q == WRITE);
    assign mem_req_addr = addr_q;
    assign mem_req_tag  = tag_q;
    assign mem_req_data = wbeats[wcnt_q];
    assign proto_error  = proto_error_q;

    assign rd_beat_val = mem_resp_val && (state_q == RD_WAIT);

    mem_line_deserializer #(
        .MEM_DATA_BITS   (MEM_DATA_BITS),
        .MEM_TAG_BITS    (MEM_TAG_BITS),
        .MEM_DATA_CYCLES (MEM_DATA_CYCLES)
    ) u_deser (
        .clk       (clk),
        .reset     (reset),
        .beat_val  (rd_beat_val),
        .beat_data (mem_resp_data),
        .txn_tag   (tag_q),
        .last_beat (rd_last_beat),
        .line_val  (line_resp_val),
        .line_data (line_resp_data),
        .line_tag  (line_resp_tag)
    );

endmodule

// File: tb/tb_mem_line_initiator.sv
// Scoreboard bench for mem_line_initiator: stimulus pushes expected beats/lines,
// a forked monitor pops and compares them as the DUT presents them.
module tb_mem_line_initiator;

    localparam int AW = 26;
    localparam int DW = 128;
    localparam int TW = 4;
    localparam int NB = 4;
    localparam int LW = DW * NB;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct {
        logic [LW-1:0] data;
        logic [TW-1:0] tag;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_req_val = 1'b0;
    logic          line_req_rdy;
    logic          line_req_rw = 1'b0;
    logic [AW-1:0] line_req_addr = '0;
    logic [LW-1:0] line_req_data = '0;
    logic [TW-1:0] line_req_tag = '0;
    logic          line_resp_val;
    logic [LW-1:0] line_resp_data;
    logic [TW-1:0] line_resp_tag;
    logic          mem_req_val;
    logic          mem_req_rdy = 1'b1;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_resp_val = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic [TW-1:0] mem_resp_tag = '0;
    logic          proto_error;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    int    checks = 0;
    int    errors = 0;
    int    hs_count = 0;
    int    watch_count = 0;
    logic [DW-1:0] watch_word = '1;

    always #5 clk = ~clk;

    mem_line_initiator dut (
        .clk            (clk),
        .reset          (reset),
        .line_req_val   (line_req_val),
        .line_req_rdy   (line_req_rdy),
        .line_req_rw    (line_req_rw),
        .line_req_addr  (line_req_addr),
        .line_req_data  (line_req_data),
        .line_req_tag   (line_req_tag),
        .line_resp_val  (line_resp_val),
        .line_resp_data (line_resp_data),
        .line_resp_tag  (line_resp_tag),
        .mem_req_val    (mem_req_val),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_resp_val   (mem_resp_val),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_tag   (mem_resp_tag),
        .proto_error    (proto_error)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Beat k of a line is {4{base+k}}, placed at bits [k*DW +: DW].
    function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++) l[k*DW +: DW] = {4{base + 32'(k)}};
        return l;
    endfunction

    function automatic logic [DW-1:0] beat_of(input logic [LW-1:0] l, input int k);
        return l[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [TW-1:0] t);
        for (int k = 0; k < NB; k++) exp_req.push_back('{1'b1, a, beat_of(l, k), t});
    endtask

    task automatic push_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
        exp_req.push_back('{1'b0, a, '0, t});
    endtask

    task automatic push_resp(input logic [LW-1:0] l, input logic [TW-1:0] t);
        exp_resp.push_back('{l, t});
    endtask

    task automatic run_monitor();
        req_t  r;
        resp_t p;
        forever begin
            @(negedge clk);
            if (!reset && mem_req_val && mem_req_rdy) begin
                hs_count++;
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req_unexpected: got beat %0h, required no beat", mem_req_data);
                end else begin
                    r = exp_req.pop_front();
                    check("mem_req_rw", mem_req_rw, r.rw);
                    check("mem_req_addr", mem_req_addr, r.addr);
                    check("mem_req_tag", mem_req_tag, r.tag);
                    if (r.rw) check("mem_req_data", mem_req_data, r.data);
                end
            end
            if (mem_req_val && mem_req_data == watch_word) watch_count++;
            if (line_resp_val) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL line_resp_unexpected: got tag %0h, required no response", line_resp_tag);
                end else begin
                    p = exp_resp.pop_front();
                    check("line_resp_data", line_resp_data, p.data);
                    check("line_resp_tag", line_resp_tag, p.tag);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rdy_during_reset", line_req_rdy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_line_req_rdy", line_req_rdy, 1'b1);
        check("rst_mem_req_val", mem_req_val, 1'b0);
        check("rst_line_resp_val", line_resp_val, 1'b0);
        check("rst_proto_error", proto_error, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Present a request and return #1 after the accepting edge (start of cycle 1).
    task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [TW-1:0] t, input bit hold);
        int n = 0;
        line_req_rw   = rw;
        line_req_addr = a;
        line_req_data = l;
        line_req_tag  = t;
        line_req_val  = 1'b1;
        @(negedge clk);
        while (!line_req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!line_req_rdy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got rdy 0 after %0d cycles, required rdy 1", n);
        end
        @(posedge clk);
        #1;
        if (!hold) line_req_val = 1'b0;
    endtask

    task automatic wait_req_hs();
        int n = 0;
        @(negedge clk);
        while (!(mem_req_val && mem_req_rdy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(mem_req_val && mem_req_rdy)) begin
            checks++;
            errors++;
            $display("FAIL req_hs_timeout: got no handshake after %0d cycles, required one", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [LW-1:0] l, input logic [TW-1:0] t, input int count);
        for (int k = 0; k < count; k++) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = beat_of(l, k);
            mem_resp_tag  = t;
            tick();
        end
        mem_resp_val = 1'b0;
    endtask

    task automatic run_stimulus();
        logic [LW-1:0] la, la2, lb, lc, ld, le, lf, lg;
        int hs0, w0;
        la  = mk_line(32'hA000_0000);
        la2 = mk_line(32'hA200_0000);
        lb  = mk_line(32'hB000_0000);
        lc  = mk_line(32'hC000_0000);
        ld  = mk_line(32'hD000_0000);
        le  = mk_line(32'hE000_0000);
        lf  = mk_line(32'hF000_0000);
        lg  = mk_line(32'h6000_0000);

        do_reset();

        // Write with rdy always high: beats in cycles 1..4, rdy back in cycle 5.
        hs0 = hs_count;
        push_write(26'h0001234, la, 4'h3);
        issue(1'b1, 26'h0001234, la, 4'h3, 1'b0);
        for (int c = 1; c <= NB; c++) begin
            @(negedge clk);
            check($sformatf("wr_val_c%0d", c), mem_req_val, 1'b1);
            check($sformatf("wr_busy_c%0d", c), line_req_rdy, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("wr_rdy_c5", line_req_rdy, 1'b1);
        check("wr_idle_c5", mem_req_val, 1'b0);
        #1;
        check("wr_handshakes", 32'(hs_count - hs0), 32'd4);
        @(posedge clk);
        #1;

        // Write with rdy low for 3 cycles on beat 2.
        hs0 = hs_count;
        w0 = watch_count;
        watch_word = beat_of(la2, 2);
        push_write(26'h0002000, la2, 4'h1);
        issue(1'b1, 26'h0002000, la2, 4'h1, 1'b0);
        tick();
        tick();
        mem_req_rdy = 1'b0;
        tick();
        tick();
        tick();
        mem_req_rdy = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("stall_rdy_back", line_req_rdy, 1'b1);
        #1;
        check("stall_beat2_held", 32'(watch_count - w0), 32'd4);
        check("stall_handshakes", 32'(hs_count - hs0), 32'd4);
        watch_word = '1;
        @(posedge clk);
        #1;

        // Read tag 5: one request beat, line one cycle after the last response beat.
        push_read(26'h3800040, 4'h5);
        push_resp(lb, 4'h5);
        issue(1'b0, 26'h3800040, '0, 4'h5, 1'b0);
        wait_req_hs();
        send_beats(lb, 4'h5, NB);
        @(negedge clk);
        check("rd_resp_val", line_resp_val, 1'b1);
        check("rd_rdy_with_resp", line_req_rdy, 1'b1);
        check("rd_proto_error", proto_error, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rd_resp_pulse", line_resp_val, 1'b0);
        @(posedge clk);
        #1;

        // Reset after beat 1 of a read: abandoned, then a clean read.
        push_read(26'h0000100, 4'h2);
        issue(1'b0, 26'h0000100, '0, 4'h2, 1'b0);
        wait_req_hs();
        send_beats(lc, 4'h2, 2);
        @(negedge clk);
        check("resp_data_stable", line_resp_data, lb);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        mem_resp_val  = 1'b1;
        mem_resp_tag  = 4'hF;
        mem_resp_data = beat_of(lc, 2);
        tick();
        tick();
        @(negedge clk);
        check("midrst_rdy_low", line_req_rdy, 1'b0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        mem_resp_val = 1'b0;
        @(negedge clk);
        check("midrst_rdy", line_req_rdy, 1'b1);
        check("midrst_mem_req_val", mem_req_val, 1'b0);
        check("midrst_resp_val", line_resp_val, 1'b0);
        check("midrst_proto_error", proto_error, 1'b0);
        @(posedge clk);
        #1;
        push_read(26'h0000200, 4'h7);
        push_resp(ld, 4'h7);
        issue(1'b0, 26'h0000200, '0, 4'h7, 1'b0);
        wait_req_hs();
        send_beats(ld, 4'h7, NB);
        @(negedge clk);
        check("after_rst_resp_val", line_resp_val, 1'b1);
        @(posedge clk);
        #1;

        // Read then write with line_req_val held: write accepted in the response cycle.
        push_read(26'h0000300, 4'h9);
        push_resp(lf, 4'h9);
        issue(1'b0, 26'h0000300, '0, 4'h9, 1'b1);
        line_req_rw   = 1'b1;
        line_req_addr = 26'h0000ABC;
        line_req_data = le;
        line_req_tag  = 4'h1;
        push_write(26'h0000ABC, le, 4'h1);
        wait_req_hs();
        send_beats(lf, 4'h9, NB);
        @(negedge clk);
        check("b2b_resp_val", line_resp_val, 1'b1);
        check("b2b_rdy", line_req_rdy, 1'b1);
        @(posedge clk);
        #1;
        line_req_val = 1'b0;
        @(negedge clk);
        check("b2b_wr_val", mem_req_val, 1'b1);
        check("b2b_wr_rw", mem_req_rw, 1'b1);
        for (int c = 0; c < NB + 1; c++) tick();

        // Stray response beat in IDLE sets the sticky error.
        do_reset();
        mem_resp_val = 1'b1;
        mem_resp_tag = 4'h0;
        tick();
        mem_resp_val = 1'b0;
        @(negedge clk);
        check("stray_proto_error", proto_error, 1'b1);
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);
        check("stray_proto_sticky", proto_error, 1'b1);
        @(posedge clk);
        #1;

        // Tag mismatch on read responses: error set, line still returned with captured tag.
        do_reset();
        push_read(26'h3800040, 4'h5);
        push_resp(lg, 4'h5);
        issue(1'b0, 26'h3800040, '0, 4'h5, 1'b0);
        wait_req_hs();
        send_beats(lg, 4'h6, NB);
        @(negedge clk);
        check("badtag_resp_val", line_resp_val, 1'b1);
        check("badtag_proto_error", proto_error, 1'b1);
        @(posedge clk);
        #1;

        for (int c = 0; c < 4; c++) tick();
        check("exp_req_drained", 32'(exp_req.size()), 32'd0);
        check("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
    endtask

    initial begin
        fork
            run_monitor();
            begin
                #200000;
                $display("FAIL watchdog: got no completion by 200000, required completion");
                $fatal(1, "watchdog expired");
            end
        join_none
        run_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
